// File: rtl/apb4_reg_bridge.sv
// APB4 completer bridging to the single-request bus_req/bus_ready register-map protocol.
// Handles stall back-pressure, response timeout and address/privilege pre-errors.
module apb4_reg_bridge #(
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH      = 11,
    parameter int unsigned PADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES  = 256,
    parameter bit          ERR_ON_MISALIGN = 1'b1,
    parameter bit          PRIV_ONLY       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [PADDR_WIDTH-1:0]    paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    output logic                      pready,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pslverr,
    output logic                      bus_req,
    output logic                      bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wr_data,
    output logic [DATA_WIDTH-1:0]     bus_wr_biten,
    input  logic                      bus_req_stall_wr,
    input  logic                      bus_req_stall_rd,
    input  logic                      bus_ready,
    input  logic                      bus_err,
    input  logic [DATA_WIDTH-1:0]     bus_rd_data
);

    localparam int unsigned STRB_W   = DATA_WIDTH / 8;
    localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned TMO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   pready_q;
    logic [DATA_WIDTH-1:0]  prdata_q;
    logic                   pslverr_q;
    logic                   is_wr_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  wdata_q;
    logic [DATA_WIDTH-1:0]  biten_q;

    logic                   setup_c;
    logic                   misalign_c;
    logic                   range_err_c;
    logic                   pre_err_c;
    logic                   stall_c;
    logic                   tmo_hit_c;
    logic                   bus_req_c;
    logic [DATA_WIDTH-1:0]  biten_c;
    logic [DATA_WIDTH-1:0]  rdata_sel_c;
    logic                   unused_prot;

    assign unused_prot = ^pprot[2:1];

    assign setup_c     = psel & ~penable;
    assign misalign_c  = (paddr & PADDR_WIDTH'(STRB_W - 1)) != '0;
    assign range_err_c = (paddr >> ADDR_WIDTH) != '0;
    assign pre_err_c   = range_err_c | (ERR_ON_MISALIGN & misalign_c) | (PRIV_ONLY & ~pprot[0]);
    assign stall_c     = is_wr_q ? bus_req_stall_wr : bus_req_stall_rd;
    assign tmo_hit_c   = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TMO_LAST));
    // A timeout expiring while still stalled in REQ must not also launch a request.
    assign bus_req_c   = (state_q == REQ) && !stall_c && !tmo_hit_c;
    assign rdata_sel_c = is_wr_q ? '0 : bus_rd_data;

    always_comb begin
        biten_c = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            biten_c[i] = pwrite & pstrb[i/8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            prdata_q  <= '0;
            pslverr_q <= 1'b0;
            is_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            biten_q   <= '0;
        end else begin
            pready_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (setup_c) begin
                        is_wr_q <= pwrite;
                        addr_q  <= paddr[ADDR_WIDTH-1:0];
                        wdata_q <= pwdata;
                        biten_q <= biten_c;
                        if (pre_err_c) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= 1'b1;
                            prdata_q  <= '0;
                        end else begin
                            state_q <= REQ;
                            cnt_q   <= '0;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (bus_req_c) begin
                        if (bus_ready) begin
                            state_q   <= RESP;
                            pready_q  <= 1'b1;
                            pslverr_q <= bus_err;
                            prdata_q  <= rdata_sel_c;
                        end else begin
                            state_q <= WAIT;
                        end
                    end else if (tmo_hit_c) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    // A response landing on the timeout cycle still wins.
                    if (bus_ready) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= bus_err;
                        prdata_q  <= rdata_sel_c;
                    end else if (tmo_hit_c) begin
                        state_q   <= RESP;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                        prdata_q  <= '0;
                    end
                end
                RESP: begin
                    state_q   <= IDLE;
                    pslverr_q <= 1'b0;
                    prdata_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pready        = pready_q;
    assign prdata        = prdata_q;
    assign pslverr       = pslverr_q;
    assign bus_req       = bus_req_c;
    assign bus_req_is_wr = is_wr_q;
    assign bus_addr      = addr_q;
    assign bus_wr_data   = wdata_q;
    assign bus_wr_biten  = biten_q;

endmodule

// File: doc/apb4_reg_bridge.md
Name: apb4_reg_bridge

Overview:
- APB4 completer that converts APB transfers into the single-request bus_req/bus_ready protocol consumed by the CSR/register-map blocks.
- Generalises the fixed 32-bit/11-bit bus-to-register link:
  - parametrised data and address widths;
  - byte strobe expanded to a per-bit write enable;
  - register-map stall honouring;
  - response timeout;
  - misalign, out-of-range and privilege error generation.
- Sits between the SoC APB fabric and one register-map instance.

Parameters:
- DATA_WIDTH, 32, APB and register data width; multiple of 8, 8..128.
- ADDR_WIDTH, 11, register-map byte address width.
- PADDR_WIDTH, 32, APB PADDR width; must be >= ADDR_WIDTH.
- TIMEOUT_CYCLES, 256, cycles to wait for bus_ready before erroring; 0 disables timeout.
- ERR_ON_MISALIGN, 1, 1 = PADDR not DATA_WIDTH/8-aligned returns PSLVERR without a register request.
- PRIV_ONLY, 0, 1 = accesses with PPROT[0]=0 return PSLVERR without a register request.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB direction, 1 = write
- paddr  in  PADDR_WIDTH  APB byte address
- pwdata  in  DATA_WIDTH  APB write data
- pstrb  in  DATA_WIDTH/8  APB write byte strobes
- pprot  in  3  APB protection
- pready  out  1  APB ready
- prdata  out  DATA_WIDTH  APB read data
- pslverr  out  1  APB error
- bus_req  out  1  register request strobe, one cycle per transfer
- bus_req_is_wr  out  1  request is a write
- bus_addr  out  ADDR_WIDTH  register byte address
- bus_wr_data  out  DATA_WIDTH  write data
- bus_wr_biten  out  DATA_WIDTH  per-bit write enable
- bus_req_stall_wr  in  1  register map cannot accept a write this cycle
- bus_req_stall_rd  in  1  register map cannot accept a read this cycle
- bus_ready  in  1  register map response valid
- bus_err  in  1  register map error, qualified by bus_ready
- bus_rd_data  in  DATA_WIDTH  read data, qualified by bus_ready

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE, timeout counter=0. All outputs 0.
- States: IDLE, REQ, WAIT, RESP.
- IDLE:
  - On psel & !penable (setup phase), latch the request:
    - bus_addr = paddr[ADDR_WIDTH-1:0]
    - bus_req_is_wr = pwrite
    - bus_wr_data = pwdata
    - bus_wr_biten: bit i = pstrb[i/8] for writes, all 0 for reads
  - Evaluate pre-errors:
    - paddr[PADDR_WIDTH-1:ADDR_WIDTH] != 0;
    - misaligned address with ERR_ON_MISALIGN=1;
    - pprot[0]=0 with PRIV_ONLY=1.
  - Any pre-error: go to RESP with pslverr=1 and prdata=0; no bus_req is issued. Otherwise go to REQ and clear the counter.
- REQ:
  - bus_req = !(pwrite_latched ? bus_req_stall_wr : bus_req_stall_rd). This is combinational from state and stall.
  - When bus_req=1 for one cycle:
    - if bus_ready is also 1 that cycle, capture the response and go to RESP;
    - otherwise go to WAIT.
- WAIT: bus_req=0. On bus_ready, capture bus_err into pslverr and bus_rd_data into prdata, then go to RESP.
  - prdata is captured only for reads; for writes it is 0.
- Timeout:
  - The counter increments each cycle in REQ and WAIT.
  - When TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1 without a response, go to RESP with pslverr=1 and prdata=0.
  - If the timeout fires while still in REQ, no bus_req is issued.
  - A bus_ready arriving in the same cycle as the timeout wins; the real response is used.
- RESP: pready=1 for exactly one cycle with registered prdata/pslverr, then go to IDLE. prdata and pslverr return to 0 in IDLE.
- Latency: minimum is setup + 2 access cycles, i.e. one APB wait state (zero-stall register map with same-cycle bus_ready).
- bus_ready is ignored in IDLE and RESP.
- Request outputs (bus_addr, bus_wr_data, bus_wr_biten, bus_req_is_wr) hold their latched value until the next setup phase.
- psel deasserted mid-transfer (protocol violation): the transfer still completes and pready pulses once; no new transfer starts until IDLE.
- Back-to-back transfers: a setup phase in the cycle after RESP is accepted normally.
- Reset asserted mid-transfer aborts immediately; no pready is produced for that transfer.

Test Plan:
- Write paddr=0x10, pwdata=0xDEADBEEF, pstrb=4'b0101, zero-stall map with same-cycle ready:
  - bus_req pulses once with bus_addr=0x010 and bus_wr_biten=0x00FF00FF;
  - pready rises 2 cycles after setup with pslverr=0.
- Read 0x7FC, map returns bus_rd_data=0x12345678 three cycles after bus_req:
  - prdata=0x12345678, pslverr=0;
  - exactly 1 bus_req pulse.
- Write with bus_req_stall_wr held 5 cycles, and a read in flight while stall_wr is high:
  - bus_req stays low for exactly 5 cycles, then pulses once;
  - the read is not blocked by stall_wr.
- TIMEOUT_CYCLES=8, map never responds:
  - pready asserts on the cycle after 8 REQ/WAIT cycles, with pslverr=1 and prdata=0;
  - the next transfer proceeds normally.
- Error cases: paddr=0x802 (out of range), paddr=0x3 (misaligned), PRIV_ONLY=1 with pprot=0:
  - each gives pslverr=1 with no bus_req issued;
  - bus_err=1 returned from the map gives pslverr=1.
- Assert rst while in WAIT:
  - all outputs go to 0 immediately and state returns to IDLE;
  - a late bus_ready after reset causes no pready.
